// File: rtl/aes_pkg.sv
// AES-128 forward tables and round helpers
// shared by the CBC encryptor datapath
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON =
    80'h01020408102040801b36;

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    if (r == 4'd0 || r > 4'd10)
      return 8'h00;
    return RCON[87 - 8*int'(r) -: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    return {sub_word(s[127:96]),
            sub_word(s[95:64]),
            sub_word(s[63:32]),
            sub_word(s[31:0])};
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] w
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    return {mix_col(s[127:96]),
            mix_col(s[95:64]),
            mix_col(s[63:32]),
            mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion:
// derives the next round key from the current one
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rc,
  output logic [127:0] next_rk
);

  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign t  = sub_word({rk[23:0], rk[31:24]})
            ^ {rc, 24'h0};
  assign n0 = rk[127:96] ^ t;
  assign n1 = rk[95:64]  ^ n0;
  assign n2 = rk[63:32]  ^ n1;
  assign n3 = rk[31:0]   ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_cbc_enc.sv
// Iterative AES-128 encryptor, one round per clock.
// AES_CBC_CHAIN_EN selects CBC chaining; else ECB.
module aes_cbc_enc
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [127:0] planetext,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] image
);

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] next_rk;
  logic [127:0] x;
  logic [127:0] sr;
  logic [127:0] mid;
  logic [127:0] last;
  logic         accept;

`ifdef AES_CBC_CHAIN_EN
  logic [127:0] chain;
  assign x = planetext ^ (in_first ? iv : chain);
`else
  logic unused_ecb;
  assign unused_ecb = ^{iv, in_first};
  assign x = planetext;
`endif

  assign accept = in_valid && in_ready;

  aes_key_step u_key_step (
    .rk      (rk),
    .rc      (rcon(rnd)),
    .next_rk (next_rk)
  );

  assign sr   = shift_rows(sub_bytes(st));
  assign mid  = mix_columns(sr) ^ next_rk;
  assign last = sr ^ next_rk;

  // Control FSM and round datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      rk        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      image     <= '0;
`ifdef AES_CBC_CHAIN_EN
      chain     <= '0;
`endif
    end else begin
      unique case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            st       <= x ^ key;
            rk       <= key;
            rnd      <= 4'd1;
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          rk <= next_rk;
          if (rnd == 4'(NR)) begin
            st        <= last;
            image     <= last;
`ifdef AES_CBC_CHAIN_EN
            chain     <= last;
`endif
            rnd       <= 4'd0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            st  <= mid;
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_enc.sv
// Directed bench for aes_cbc_enc with an
// independent AES decrypt model for round trips
module tb_aes_cbc_enc;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [127:0] planetext;
  logic [127:0] key;
  logic [127:0] iv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] image;

  int pass  = 0;
  int total = 0;

  logic [7:0] sb [256];
  logic [7:0] isb[256];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P21 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P22 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] E22 = 128'hf5d3d58503b9699de785895a96fdbaaf;
`ifdef AES_CBC_CHAIN_EN
  localparam logic [127:0] X21 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] X22 = 128'h5086cb9b507219ee95db113a917678b2;
`else
  localparam logic [127:0] X21 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] X22 = E22;
`endif

  aes_cbc_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .planetext (planetext),
    .key       (key),
    .iv        (iv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .image     (image)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = mul2(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
        ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    logic [127:0] u;
    logic [7:0]   a0, a1, a2, a3;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
          ^ {rc, 24'h0};
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = ct ^ {w[40], w[41], w[42], w[43]};
    for (int rr = 9; rr >= 0; rr--) begin
      u = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          u[127-8*(4*((c+r)%4)+r) -: 8] = isb[s[127-8*(4*c+r) -: 8]];
      s = u ^ {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
      if (rr > 0)
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[127-32*c -: 32];
          s[127-32*c -: 32] = {
            gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
        end
    end
    return s;
  endfunction

  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] v, input logic f);
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    planetext = pt;
    key       = k;
    iv        = v;
    in_first  = f;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    planetext = '0; key = '0; iv = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
    else pass++;
    total++;
    if (image !== 128'h0) $display("FAIL rst_image got %h want 0", image);
    else pass++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready);
    else pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready_after got %b want 1", in_ready);
    else pass++;
  endtask

  task automatic test_fips_c1();
    bit got;
    int cyc;
    send(P1, K1, 128'h0, 1'b1);
    wait_out(got, cyc);
    total++;
    if (!got || cyc != 10) $display("FAIL c1_latency got %0d want 10", cyc);
    else pass++;
    total++;
    if (image !== C1) $display("FAIL c1_image got %h want %h", image, C1);
    else pass++;
    handshake();
    total++;
    if (in_ready !== 1'b1) $display("FAIL c1_ready_after got %b want 1", in_ready);
    else pass++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL c1_valid_after got %b want 0", out_valid);
    else pass++;
  endtask

  task automatic test_cbc_chain();
    bit got;
    int cyc;
    send(P21, K2, IV2, 1'b1);
    wait_out(got, cyc);
    total++;
    if (!got || image !== X21) $display("FAIL chain_blk1 got %h want %h", image, X21);
    else pass++;
    handshake();
    send(P22, K2, {128{1'b1}}, 1'b0);
    wait_out(got, cyc);
    total++;
    if (!got || image !== X22) $display("FAIL chain_blk2 got %h want %h", image, X22);
    else pass++;
    handshake();
  endtask

  task automatic test_backpressure();
    bit got;
    int cyc;
    int vcnt;
    send(P1, K1, 128'h0, 1'b1);
    wait_out(got, cyc);
    total++;
    if (!got) $display("FAIL bp_no_output got 0 want 1");
    else pass++;
    planetext = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    key = K2; iv = IV2; in_first = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid);
      else pass++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready);
      else pass++;
      total++;
      if (image !== C1) $display("FAIL bp_image cyc %0d got %h want %h", i, image, C1);
      else pass++;
    end
    in_valid = 1'b0;
    handshake();
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", in_ready);
    else pass++;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vcnt++;
    end
    total++;
    if (vcnt != 0) $display("FAIL bp_ghost_block got %0d want 0", vcnt);
    else pass++;
  endtask

  task automatic test_reset_mid();
    bit got;
    int cyc;
    int vcnt;
    send(P21, K2, IV2, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid);
    else pass++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL rmid_ready got %b want 0", in_ready);
    else pass++;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vcnt++;
    end
    total++;
    if (vcnt != 0) $display("FAIL rmid_aborted_out got %0d want 0", vcnt);
    else pass++;
    send(P22, K2, IV2, 1'b0);
    wait_out(got, cyc);
    total++;
    if (!got || cyc != 10) $display("FAIL rmid_latency got %0d want 10", cyc);
    else pass++;
    total++;
    if (image !== E22) $display("FAIL rmid_image got %h want %h", image, E22);
    else pass++;
    handshake();
  endtask

  task automatic test_roundtrip();
    bit           got;
    int           cyc;
    logic [127:0] k, v, prev, pt, ct, rec;
    k = {$urandom, $urandom, $urandom, $urandom};
    v = {$urandom, $urandom, $urandom, $urandom};
    prev = v;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(pt, k, v, b == 0);
      wait_out(got, cyc);
      ct = image;
      total++;
      if (!got || cyc != 10) $display("FAIL rt_latency blk %0d got %0d want 10", b, cyc);
      else pass++;
`ifdef AES_CBC_CHAIN_EN
      rec = aes_dec(ct, k) ^ prev;
`else
      rec = aes_dec(ct, k);
`endif
      total++;
      if (rec !== pt) $display("FAIL rt_block %0d got %h want %h", b, rec, pt);
      else pass++;
      prev = ct;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_cbc_chain();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
